// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a valid/ready upstream handshake.
// Sends one frame: START, DATA_BITS data bits LSB first, an optional parity bit,
// then STOP_BITS stop bits. The serial line is registered and idles high.
module uart_tx_cfg #(
   parameter int CLKS_PER_BIT = 217,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_ready,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 tx_ready,
   output logic                 data_out,
   output logic                 trans_active,
   output logic                 done_sig
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic HAS_PAR   = (PARITY != 0);
   localparam logic STOP_LAST = (STOP_BITS == 2);

   // Reject unsupported configurations at elaboration time.
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_cfg: CLKS_PER_BIT must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t                state, state_nxt;
   logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
   logic [IDX_W-1:0]      bit_idx, idx_nxt;
   logic                  stop_idx, stop_nxt;
   logic [DATA_BITS-1:0]  hold, hold_nxt;
   logic                  line_nxt;
   logic                  done_nxt;
   logic                  bit_end;
   logic                  accept;

   // Parity over the latched word: odd mode inverts the XOR reduction.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
      if (PARITY == 1) return ~(^word);
      return ^word;
   endfunction

   assign tx_ready     = (state == IDLE) && !rst;
   assign accept       = data_ready && tx_ready;
   assign bit_end      = (baud_cnt == BAUD_LAST);
   assign trans_active = (state != IDLE);

   // Next-state, counter and hold-register decode.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      idx_nxt   = bit_idx;
      stop_nxt  = stop_idx;
      hold_nxt  = hold;
      done_nxt  = 1'b0;
      if (state != IDLE) begin
         baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;
      end
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = START;
               hold_nxt  = data_in;
               baud_nxt  = '0;
               idx_nxt   = '0;
               stop_nxt  = 1'b0;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == IDX_LAST) state_nxt = HAS_PAR ? PAR : STOP;
               else                     idx_nxt   = bit_idx + 1'b1;
            end
         end
         PAR: begin
            if (bit_end) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (stop_idx == STOP_LAST) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  stop_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Line level for the upcoming cycle, so data_out can be a plain register.
   always_comb begin
      line_nxt = 1'b1;
      case (state_nxt)
         IDLE:    line_nxt = 1'b1;
         START:   line_nxt = 1'b0;
         DATA:    line_nxt = hold_nxt[idx_nxt];
         PAR:     line_nxt = parity_bit(hold_nxt);
         STOP:    line_nxt = 1'b1;
         default: line_nxt = 1'b1;
      endcase
   end

   // Control state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         data_out <= 1'b1;
         done_sig <= 1'b0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= idx_nxt;
         stop_idx <= stop_nxt;
         data_out <= line_nxt;
         done_sig <= done_nxt;
      end
   end

   // Word hold register; only loaded on handshake, so it needs no reset.
   always_ff @(posedge clk) begin
      hold <= hold_nxt;
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg over five parameter sets.
// Instance map: 0 = 8N1 @4, 1 = 8E1 @4, 2 = 8O1 @4, 3 = 7N2 @4, 4 = 8N1 @217.
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       dr;
   logic [8:0] din;
   int         sel;
   int         passed = 0;
   int         fails  = 0;
   int         total  = 0;

   wire [4:0] drv = dr ? 5'(5'b00001 << sel) : 5'b00000;
   wire [4:0] rdy;
   wire [4:0] line;
   wire [4:0] act;
   wire [4:0] dn;

   always #5 clk = ~clk;

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .data_ready(drv[0]), .data_in(din[7:0]),
      .tx_ready(rdy[0]), .data_out(line[0]), .trans_active(act[0]), .done_sig(dn[0]));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .data_ready(drv[1]), .data_in(din[7:0]),
      .tx_ready(rdy[1]), .data_out(line[1]), .trans_active(act[1]), .done_sig(dn[1]));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .clk(clk), .rst(rst), .data_ready(drv[2]), .data_in(din[7:0]),
      .tx_ready(rdy[2]), .data_out(line[2]), .trans_active(act[2]), .done_sig(dn[2]));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .clk(clk), .rst(rst), .data_ready(drv[3]), .data_in(din[6:0]),
      .tx_ready(rdy[3]), .data_out(line[3]), .trans_active(act[3]), .done_sig(dn[3]));
   uart_tx_cfg #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
      .clk(clk), .rst(rst), .data_ready(drv[4]), .data_in(din[7:0]),
      .tx_ready(rdy[4]), .data_out(line[4]), .trans_active(act[4]), .done_sig(dn[4]));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {data_out, trans_active, done_sig, tx_ready} of the selected instance
   function automatic logic [3:0] status();
      return {line[sel], act[sel], dn[sel], rdy[sel]};
   endfunction

   // Present a word, check the block is ready, and let the accepting edge pass.
   task automatic send(input string tag, input int s, input logic [8:0] w);
      sel = s;
      din = w;
      dr  = 1'b1;
      chk({tag, "_rdy"}, 32'(rdy[sel]), 32'd1);
      step();
   endtask

   // Starting in the first cycle after acceptance, check every cycle of the frame
   // against the expected line bits (bit i of bits = i-th bit on the line), then the
   // single IDLE cycle that carries done_sig.
   task automatic run_frame(input string tag, input int c, input int n, input logic [15:0] bits);
      for (int i = 0; i < n * c; i++) begin
         chk({tag, "_line"}, 32'(line[sel]), 32'(bits[i / c]));
         chk({tag, "_ctl"}, 32'({act[sel], dn[sel], rdy[sel]}), 32'b100);
         step();
      end
      chk({tag, "_end"}, 32'(status()), 32'b1011);
   endtask

   initial begin
      rst = 1'b1;
      dr  = 1'b0;
      din = '0;
      sel = 0;
      repeat (3) step();
      for (int s = 0; s < 5; s++) begin
         sel = s;
         chk("reset_state", 32'(status()), 32'b1000);
      end
      sel = 0;
      rst = 1'b0;
      step();
      chk("reset_release", 32'(status()), 32'b1001);

      // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1
      send("n81", 0, 9'h0A5);
      dr = 1'b0;
      run_frame("n81", 4, 10, 16'h034A);
      step();
      chk("n81_post", 32'(status()), 32'b1001);

      // Even parity, 0x03: 0,1,1,0,0,0,0,0,0,P=0,1
      send("even", 1, 9'h003);
      dr = 1'b0;
      run_frame("even", 4, 11, 16'h0406);
      step();
      chk("even_post", 32'(status()), 32'b1001);

      // Odd parity, 0x03: parity bit 1
      send("odd", 2, 9'h003);
      dr = 1'b0;
      run_frame("odd", 4, 11, 16'h0606);
      step();
      chk("odd_post", 32'(status()), 32'b1001);

      // 7 data bits, 2 stop bits, 0x55: 0,1,0,1,0,1,0,1,1,1
      send("d7s2", 3, 9'h055);
      dr = 1'b0;
      run_frame("d7s2", 4, 10, 16'h03AA);
      step();
      chk("d7s2_post", 32'(status()), 32'b1001);

      // Back to back with data_ready held; data_in changes while frames are in flight
      send("b2b1", 0, 9'h00F);
      din = 9'h0F0;
      run_frame("b2b1", 4, 10, 16'h021E);
      step();
      din = 9'h000;
      dr  = 1'b0;
      run_frame("b2b2", 4, 10, 16'h03E0);
      step();
      chk("b2b_post", 32'(status()), 32'b1001);

      // Reset during data bit 3 of 0xA5 (line low at that point)
      send("rst", 0, 9'h0A5);
      dr = 1'b0;
      repeat (17) step();
      chk("rst_pre", 32'(line[sel]), 32'd0);
      rst = 1'b1;
      step();
      chk("rst_hit", 32'(status()), 32'b1000);
      step();
      chk("rst_hold", 32'(status()), 32'b1000);
      rst = 1'b0;
      step();
      chk("rst_rel", 32'(status()), 32'b1001);
      for (int i = 0; i < 45; i++) begin
         chk("rst_nodone", 32'(status()), 32'b1001);
         step();
      end
      send("fresh", 0, 9'h0A5);
      dr = 1'b0;
      run_frame("fresh", 4, 10, 16'h034A);
      step();
      chk("fresh_post", 32'(status()), 32'b1001);

      // 217 clocks per bit: every cycle checked against the bit grid
      send("slow", 4, 9'h0A5);
      dr = 1'b0;
      run_frame("slow", 217, 10, 16'h034A);
      step();
      chk("slow_post", 32'(status()), 32'b1001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that serialises one data word per frame onto `data_out`. Data width, parity mode, stop-bit count and bit period are compile-time parameters. The upstream producer uses a valid/ready handshake, so frames can be queued back to back. The block drives the board-level TX pin directly and follows the fixed 8N1 `uart_tx` as the standard TX engine for new designs.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per serial bit (clk freq / baud); legal range ≥ 2.
- `DATA_BITS`, 8, data bits per frame; legal range 5–9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.

Ports:
- `clk` in 1 — the single clock; all logic is on its rising edge.
- `rst` in 1 — reset, synchronous and active-high.
- `data_ready` in 1 — producer has a valid word on `data_in`.
- `data_in` in `DATA_BITS` — word to transmit; sampled only on handshake.
- `tx_ready` out 1 — block can accept a word this cycle.
- `data_out` out 1 — serial line; idles high; registered.
- `trans_active` out 1 — a frame is on the line (START through STOP).
- `done_sig` out 1 — one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PAR, STOP.
- **Handshake:** a word is accepted on the rising edge where `data_ready && tx_ready`. At that edge `data_in` is copied into a shift/hold register and the FSM moves to START. Changes on `data_in` after acceptance have no effect.
- **`tx_ready`:** equals (state == IDLE) && !rst, decoded from the state register.
- **IDLE:** `data_out` = 1 and `trans_active` = 0.
- **START:** `data_out` = 0 for CLKS_PER_BIT cycles, then DATA.
- **DATA:** bits are sent LSB first, each for CLKS_PER_BIT cycles. After bit DATA_BITS−1 the FSM goes to PAR if PARITY ≠ 0, otherwise to STOP.
- **PAR:** one bit for CLKS_PER_BIT cycles.
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = inverted XOR of the data bits.
  - The parity value is computed from the latched word, never from the live `data_in`.
- **STOP:** `data_out` = 1 for STOP_BITS × CLKS_PER_BIT cycles, then IDLE with `done_sig` = 1 for exactly that one cycle.
- **Bit period:** every bit lasts exactly CLKS_PER_BIT cycles, with no extra cycle per bit.
  - Baud counter: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT−1; it wraps to 0 on each bit boundary.
  - Bit index counter: $clog2(DATA_BITS) bits; cleared on entry to START.
- **`trans_active`:** 1 in START, DATA, PAR and STOP; 0 otherwise.
- **Reset** (`rst` = 1 at an edge), including mid-frame:
  - FSM returns to IDLE and counters clear.
  - Outputs after that edge: `data_out` = 1, `trans_active` = 0, `done_sig` = 0.
  - `tx_ready` = 0 while `rst` is high, and 1 on the first cycle after release.
  - A frame aborted by reset produces no `done_sig`.
- **Illegal parameter values:** rejected at elaboration with `$error`.

## Timing
- **Frame length:** F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Start of frame:** with acceptance at edge T, `data_out` falls to 0 in the cycle after T; `trans_active` rises in the same cycle.
- **End of frame:** the final stop-bit cycle is cycle T+F. The cycle after it (T+F+1) is IDLE, with `done_sig` = 1, `tx_ready` = 1 and `data_out` = 1.
- **Back to back:** if `data_ready` is held high, the next word is accepted at the end of that IDLE cycle. The minimum inter-frame gap is therefore one cycle of idle-high line.
- **`data_ready` outside IDLE:** ignored; the word is not accepted and does not corrupt the frame in progress.
- **Reset values:**
  - `data_out` = 1
  - `trans_active` = 0
  - `done_sig` = 0
  - `tx_ready` = 0 while reset is asserted

## Test plan
- **8N1 basic.** CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5.
  - Line, in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - 40 cycles total, then a one-cycle `done_sig`.
- **Even and odd parity.** Send 0x03.
  - Even parity: parity bit 0.
  - Odd parity: parity bit 1.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- **7 data bits, 2 stop bits.** DATA_BITS=7, STOP_BITS=2; send 0x55.
  - Line: 0,1,0,1,0,1,0,1,1,1.
  - `tx_ready` returns exactly 40 cycles after the start bit began.
- **Back to back.** Hold `data_ready` high with 0x0F then 0xF0.
  - Exactly one idle-high cycle between frames.
  - Two `done_sig` pulses.
  - Changing `data_in` mid-frame does not alter the bits on the line.
- **Reset mid-frame.** Assert `rst` during data bit 3.
  - Next cycle: `data_out` = 1 and `trans_active` = 0.
  - No `done_sig`.
  - `tx_ready` = 1 on the first cycle after `rst` is released; a fresh 0xA5 then transmits correctly.
- **Bit-period check.** CLKS_PER_BIT=217.
  - Every level change on `data_out` falls on a multiple of 217 cycles from the start-bit edge.
